alu_accumulator: RTL
====================

// Module: alu_accumulator
// PURPOSE
//  Command sequencer and 32-bit accumulator around the Project 3 ALU operation modules (NOR etc.).
//  Accepts commands over a valid/ready handshake and drives the operands of the selected op
//  (alu_a = acc[15:0], alu_b = cmd_data). It then latches the op's 32-bit result back into acc.
//  It is both the upstream operand source and the downstream result sink of the op modules.
// PARAMETERS
//  ALU_LAT  1  cycles between operand issue and result capture; legal range 1..15
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   block can accept a command
//  cmd_op      in   4   0=NOP 1=LOAD 2=CLR 3..15=ALU op (forwarded as alu_sel)
//  cmd_data    in   16  LOAD value, or ALU operand B
//  alu_a       out  16  operand A to op modules (registered)
//  alu_b       out  16  operand B to op modules (registered)
//  alu_sel     out  4   op select to result mux (registered)
//  alu_result  in   32  selected op output (outputC of the op module)
//  acc         out  32  accumulator
//  acc_valid   out  1   one-cycle pulse: acc just updated
//  err         out  1   sticky: an ALU result had nonzero bits [31:16]
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; acc, alu_a, alu_b, alu_sel, counter = 0; acc_valid=0; err=0.
//  States: IDLE, ISSUE. cmd_ready = (state==IDLE), combinational from state.
//  Accept = cmd_valid & cmd_ready at a rising edge (E0). The block samples cmd_op/cmd_data only at accept.
//  NOP at E0: no state change; acc_valid stays 0.
//  LOAD at E0: acc <= {16'h0, cmd_data}; acc_valid=1 for the cycle after E0; stay IDLE.
//  CLR at E0: acc <= 0; err <= 0; acc_valid=1 for the cycle after E0; stay IDLE.
//  ALU op at E0: alu_a <= acc[15:0], alu_b <= cmd_data, alu_sel <= cmd_op; counter <= ALU_LAT;
//    state <= ISSUE.
//  ISSUE: counter decrements each edge. At the edge where counter==1 the block does all of:
//    acc <= alu_result; err <= err | (|alu_result[31:16]); acc_valid=1 next cycle; state <= IDLE.
//    Latency is therefore accept edge E0 -> acc updated at edge E0+ALU_LAT.
//  alu_a/alu_b/alu_sel hold their values after capture until the next ALU-op accept.
//  The op modules are combinational. alu_result is sampled only at the capture edge; other values are ignored.
//  While in ISSUE: cmd_ready=0. A held cmd_valid is accepted in the first IDLE cycle.
//    That cycle is the same cycle acc_valid is high. Commands are never dropped or duplicated.
//  Back-to-back: a command accepted in the acc_valid cycle sees the updated acc (alu_a = new acc[15:0]).
//  acc is 32 bits with no truncation. Only acc[15:0] is fed back as operand A.
//  err remains set through LOAD and ALU ops. Only CLR or rst clears it.
//  rst mid-ISSUE aborts the op: no capture, no acc_valid, and IDLE on release.
//  cmd_op values 3..15 are all treated as ALU ops. Decoding them is the op mux's job, not this block's.
// TESTING  (bench result mux: sel 7 -> NOR module; sel 3 -> stub returning 32'h0001_0000)
//  1. rst pulse -> acc=0, acc_valid=0, err=0, cmd_ready=1, alu_a=alu_b=0.
//  2. LOAD 16'h00FF -> acc=32'h0000_00FF at next edge; acc_valid high exactly 1 cycle.
//  3. LOAD 16'h0F0F; NOR (op 7) data 16'h00F0 -> alu_a=0F0F, alu_b=00F0;
//     ALU_LAT edges later acc=32'h0000_F000.
//  4. ALU_LAT=3, hold cmd_valid with two NORs (data 0x0000) after LOAD 0 -> cmd_ready low 3 cycles.
//     First result is acc=32'h0000_FFFF. Second NOR gets alu_a=FFFF and gives acc=0. Exactly 2 acc_valid pulses.
//  5. op 3 -> acc=32'h0001_0000, err=1; LOAD 1 -> err still 1; CLR -> acc=0, err=0.
//  6. ALU_LAT=4, assert rst in 2nd ISSUE cycle -> acc=0 and cmd_ready=1 at once; no acc_valid pulse follows.

Source files
------------

// File: rtl/alu_accumulator.sv
// alu_accumulator: command sequencer and 32-bit accumulator wrapped around
// a set of combinational ALU op modules. It issues registered operands to
// the op modules and captures the selected result ALU_LAT cycles later.
module alu_accumulator #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_result,
    output logic [31:0] acc,
    output logic        acc_valid,
    output logic        err
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_CLR  = 4'd2;
    localparam logic [3:0] LAT     = 4'(ALU_LAT);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;
    logic        accept;
    logic        is_alu_op;
    logic        capture;

    // Anything that is not NOP/LOAD/CLR is an ALU op; decoding is the mux's job.
    assign is_alu_op = (cmd_op != OP_NOP) && (cmd_op != OP_LOAD) && (cmd_op != OP_CLR);
    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // Capture happens on the last ISSUE cycle, when the countdown reaches 1.
    assign capture   = (state == ISSUE) && (counter == 4'd1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave IDLE on an ALU-op accept, return on capture.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_alu_op) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (counter == 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latency countdown: loaded on ALU-op accept, decremented while issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= 4'd0;
        end else if (accept && is_alu_op) begin
            counter <= LAT;
        end else if (state == ISSUE) begin
            counter <= counter - 4'd1;
        end
    end

    // Operand registers: updated only on ALU-op accept, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= 16'd0;
            alu_b   <= 16'd0;
            alu_sel <= 4'd0;
        end else if (accept && is_alu_op) begin
            alu_a   <= acc[15:0];
            alu_b   <= cmd_data;
            alu_sel <= cmd_op;
        end
    end

    // Accumulator, sticky error and one-cycle update strobe.
    // capture and accept are exclusive because accept needs IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 32'd0;
            err       <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (capture) begin
                acc       <= alu_result;
                err       <= err | (|alu_result[31:16]);
                acc_valid <= 1'b1;
            end else if (accept) begin
                if (cmd_op == OP_LOAD) begin
                    acc       <= {16'h0000, cmd_data};
                    acc_valid <= 1'b1;
                end else if (cmd_op == OP_CLR) begin
                    acc       <= 32'd0;
                    err       <= 1'b0;
                    acc_valid <= 1'b1;
                end
            end
        end
    end

endmodule
